// File: rtl/m_axi4l_cmd_master_pkg.sv
// rtl/m_axi4l_cmd_master_pkg.sv - shared FSM encoding, AXI response codes and constant sideband values
package m_axi4l_cmd_master_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_REQ  = 3'd1;
    localparam logic [2:0] ST_WR_RESP = 3'd2;
    localparam logic [2:0] ST_RD_REQ  = 3'd3;
    localparam logic [2:0] ST_RD_RESP = 3'd4;
    localparam logic [2:0] ST_RSP     = 3'd5;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Fixed sideband values driven on every request
    localparam logic [2:0] AXI_PROT  = 3'b000;
    localparam logic [3:0] AXI_CACHE = 4'b0000;

endpackage

// File: rtl/m_axi4l_cmd_master.sv
// rtl/m_axi4l_cmd_master.sv - single-outstanding command/response to AXI4-Lite master
//
// Purpose: accepts one write/read command at a time, runs the matching AXI4-Lite
// transaction and returns a single response (echoed type, read data, BRESP/RRESP).
// Optional feature macro: M_AXI4L_STATS_EN adds o_wr_count / o_rd_count.
//
// Ports:
//   i_axi_clock, i_axi_aresetn      clock, async active-low reset
//   i_cmd_* / o_cmd_ready           command handshake and payload
//   o_rsp_* / i_rsp_ready           response handshake and payload
//   o_axi_aw* / o_axi_w* / *b*      AXI write address, data, response channels
//   o_axi_ar* / *r*                 AXI read address and data channels
//   o_wr_count, o_rd_count          completed-transaction counters (macro only)
module m_axi4l_cmd_master
    import m_axi4l_cmd_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      i_axi_clock,
    input  logic                      i_axi_aresetn,
`ifdef M_AXI4L_STATS_EN
    output logic [15:0]               o_wr_count,
    output logic [15:0]               o_rd_count,
`endif
    input  logic                      i_cmd_valid,
    output logic                      o_cmd_ready,
    input  logic                      i_cmd_write,
    input  logic [ADDR_WIDTH-1:0]     i_cmd_addr,
    input  logic [DATA_WIDTH-1:0]     i_cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   i_cmd_wstrb,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic                      o_rsp_write,
    output logic [DATA_WIDTH-1:0]     o_rsp_rdata,
    output logic [1:0]                o_rsp_resp,
    output logic [ADDR_WIDTH-1:0]     o_axi_awaddr,
    output logic [2:0]                o_axi_awprot,
    output logic                      o_axi_awaddr_valid,
    input  logic                      i_axi_awaddr_ready,
    output logic [DATA_WIDTH-1:0]     o_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   o_axi_wstrb,
    output logic                      o_axi_wdata_valid,
    input  logic                      i_axi_wdata_ready,
    input  logic [1:0]                i_axi_bresp,
    input  logic                      i_axi_bvalid,
    output logic                      o_axi_bready,
    output logic [ADDR_WIDTH-1:0]     o_axi_araddr,
    output logic [3:0]                o_axi_arcache,
    output logic [2:0]                o_axi_arprot,
    output logic                      o_axi_araddr_valid,
    input  logic                      i_axi_araddr_ready,
    input  logic [DATA_WIDTH-1:0]     i_axi_rdata,
    input  logic [1:0]                i_axi_rresp,
    input  logic                      i_axi_rdata_valid,
    output logic                      o_axi_rdata_ready
);

    logic [2:0]              state_q,     state_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q,    awaddr_d;
    logic                    awvalid_q,   awvalid_d;
    logic [DATA_WIDTH-1:0]   wdata_q,     wdata_d;
    logic [DATA_WIDTH/8-1:0] wstrb_q,     wstrb_d;
    logic                    wvalid_q,    wvalid_d;
    logic                    bready_q,    bready_d;
    logic [ADDR_WIDTH-1:0]   araddr_q,    araddr_d;
    logic                    arvalid_q,   arvalid_d;
    logic                    rready_q,    rready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_write_q, rsp_write_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]              rsp_resp_q,  rsp_resp_d;

    // A write-request channel counts as done once its valid has already dropped
    // or its handshake happens this cycle; AW and W finish independently.
    logic aw_done, w_done, rsp_hs;
    assign aw_done = !awvalid_q || i_axi_awaddr_ready;
    assign w_done  = !wvalid_q  || i_axi_wdata_ready;
    assign rsp_hs  = rsp_valid_q && i_rsp_ready;

    // State register and registered outputs
    always_ff @(posedge i_axi_clock or negedge i_axi_aresetn) begin
        if (!i_axi_aresetn) begin
            state_q     <= ST_IDLE;
            awaddr_q    <= '0;
            awvalid_q   <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
        end else begin
            state_q     <= state_d;
            awaddr_q    <= awaddr_d;
            awvalid_q   <= awvalid_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (i_cmd_valid) state_d = i_cmd_write ? ST_WR_REQ : ST_RD_REQ;
            ST_WR_REQ:  if (aw_done && w_done) state_d = ST_WR_RESP;
            ST_WR_RESP: if (i_axi_bvalid) state_d = ST_RSP;
            ST_RD_REQ:  if (i_axi_araddr_ready) state_d = ST_RD_RESP;
            ST_RD_RESP: if (i_axi_rdata_valid) state_d = ST_RSP;
            ST_RSP:     if (i_rsp_ready) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        awaddr_d    = awaddr_q;
        awvalid_d   = awvalid_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        araddr_d    = araddr_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    if (i_cmd_write) begin
                        awaddr_d  = i_cmd_addr;
                        wdata_d   = i_cmd_wdata;
                        wstrb_d   = i_cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        araddr_d  = i_cmd_addr;
                        arvalid_d = 1'b1;
                    end
                end
            end
            ST_WR_REQ: begin
                if (awvalid_q && i_axi_awaddr_ready) awvalid_d = 1'b0;
                if (wvalid_q && i_axi_wdata_ready)   wvalid_d  = 1'b0;
                if (aw_done && w_done)               bready_d  = 1'b1;
            end
            ST_WR_RESP: begin
                if (i_axi_bvalid) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = i_axi_bresp;
                end
            end
            ST_RD_REQ: begin
                if (i_axi_araddr_ready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            ST_RD_RESP: begin
                if (i_axi_rdata_valid) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = i_axi_rdata;
                    rsp_resp_d  = i_axi_rresp;
                end
            end
            ST_RSP: begin
                if (i_rsp_ready) rsp_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

`ifdef M_AXI4L_STATS_EN
    logic [15:0] wr_count_q, wr_count_d;
    logic [15:0] rd_count_q, rd_count_d;

    // Counters wrap naturally at 16 bits
    always_comb begin
        wr_count_d = wr_count_q;
        rd_count_d = rd_count_q;
        if (rsp_hs &&  rsp_write_q) wr_count_d = wr_count_q + 16'd1;
        if (rsp_hs && !rsp_write_q) rd_count_d = rd_count_q + 16'd1;
    end

    always_ff @(posedge i_axi_clock or negedge i_axi_aresetn) begin
        if (!i_axi_aresetn) begin
            wr_count_q <= 16'd0;
            rd_count_q <= 16'd0;
        end else begin
            wr_count_q <= wr_count_d;
            rd_count_q <= rd_count_d;
        end
    end

    assign o_wr_count = wr_count_q;
    assign o_rd_count = rd_count_q;
`else
    logic unused_rsp_hs;
    assign unused_rsp_hs = rsp_hs;
`endif

    assign o_cmd_ready        = (state_q == ST_IDLE);
    assign o_rsp_valid        = rsp_valid_q;
    assign o_rsp_write        = rsp_write_q;
    assign o_rsp_rdata        = rsp_rdata_q;
    assign o_rsp_resp         = rsp_resp_q;
    assign o_axi_awaddr       = awaddr_q;
    assign o_axi_awprot       = AXI_PROT;
    assign o_axi_awaddr_valid = awvalid_q;
    assign o_axi_wdata        = wdata_q;
    assign o_axi_wstrb        = wstrb_q;
    assign o_axi_wdata_valid  = wvalid_q;
    assign o_axi_bready       = bready_q;
    assign o_axi_araddr       = araddr_q;
    assign o_axi_arcache      = AXI_CACHE;
    assign o_axi_arprot       = AXI_PROT;
    assign o_axi_araddr_valid = arvalid_q;
    assign o_axi_rdata_ready  = rready_q;

endmodule
